hopfield_recall_ctrl: RTL and testbench
=======================================

Name: hopfield_recall_ctrl

Overview:
- Sequences recall on the 25-neuron Hopfield network.
- Replaces the single-cycle 625-term combinational sum with a serial walk over the link memory: one weight fetched per cycle, one neuron committed per N+2 cycles.
- Updates are in place (asynchronous Hopfield).
- Repeats full sweeps until a sweep changes no neuron, or until MAX_SWEEPS is reached.
- Sits between the button/debounce logic (start, load) and the link-weight RAM, which is written by the learning logic. It drives the neuron vector shown on the LED matrix.

Parameters:
- N, 25, neuron count; link array is N*N.
- WW, 4, signed weight width.
- SUMW, 8, signed accumulator width; must hold N*max|w|; 125 for |w|<=5.
- AW, 10, link address width; ceil(log2(N*N)).
- MAX_SWEEPS, 8, sweep limit before giving up.
- INIT_PATTERN, 25'b0111010011100100001001110, neuron state after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  single-cycle pulse; begin recall
- load  in  1  single-cycle pulse; copy load_pattern into neuros
- load_pattern  in  N  probe/noisy pattern
- link_rd_en  out  1  link RAM read enable
- link_addr  out  AW  link RAM address, k*N+m
- link_data  in  WW  signed weight; valid 1 cycle after link_rd_en (synchronous RAM)
- neuros  out  N  current neuron state
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse at end of recall
- converged  out  1  valid from done until the next accepted start; 1 = stable sweep reached
- sweep_count  out  4  sweeps completed in the current or last recall

Behaviour:
- Reset: rst, synchronous, active-low.
  - Reset values: neuros=INIT_PATTERN, busy=0, done=0, converged=0, sweep_count=0, link_rd_en=0, link_addr=0, FSM=IDLE.
  - Reset mid-recall aborts immediately; no done pulse is emitted.
- States: IDLE, FETCH, DRAIN, COMMIT, SWEEP_END, FINISH.
- IDLE:
  - load=1: neuros<=load_pattern.
  - start=1 with load=0: k=0, m=0, sum=0, changed=0, sweep_count=0, converged=0, go to FETCH.
  - start and load in the same cycle: load wins; start is dropped.
- FETCH:
  - Each cycle: link_rd_en=1, link_addr=k*N+m, m++.
  - Each cycle after the first, accumulate the returning data: sum += neuros[m-1] ? w : -w.
  - After m=N-1 is issued, go to DRAIN.
- DRAIN: link_rd_en=0; accumulate the last weight.
- COMMIT:
  - new = (sum > 0) ? 1 : 0; sum == 0 gives 0.
  - If new != neuros[k], set changed=1.
  - neuros[k] <= new. Later neurons in the same sweep see the updated bit.
  - sum=0, m=0.
  - k<N-1: k++, go to FETCH. Otherwise go to SWEEP_END.
- Timing: N+2 = 27 cycles per neuron; 675 cycles per sweep.
- SWEEP_END: sweep_count++. Then:
  - changed=0: converged<=1, go to FINISH.
  - sweep_count+1 == MAX_SWEEPS: converged<=0, go to FINISH.
  - Otherwise: k=0, changed=0, go to FETCH.
- FINISH: done=1 for one cycle, busy=0 on the same cycle, go to IDLE.
- Ignored inputs: start and load while busy are ignored.
- Arithmetic: sign-extend link_data to SUMW. Two's complement wrap is permitted, since overflow cannot occur for |w|<=5.
- Latency: start accepted at cycle 0 → busy=1 at cycle 1 → done at cycle 1 + S*675 + 1, where S = sweeps run.

Decomposition:
- Package hopfield_pkg holds:
  - constants N, AW, WW, SUMW;
  - the state enum;
  - a function link_index(k,m) = k*N+m.
- Sub-module hopfield_mac: signed accumulator with clear, add/sub select (neuron bit) and threshold output (sum>0).
  - The controller owns the FSM, the k/m counters and the neuron register.

Test Plan:
- All weights 0, start → every sum is 0, so neuros becomes 0 after sweep 1. Sweep 2 is unchanged, so done at 1+1350+1 cycles, converged=1, sweep_count=2.
- w(k,k)=+1, others 0, INIT_PATTERN → no change. done after 1 sweep (677 cycles), converged=1, neuros=INIT_PATTERN.
- w(k,k)=-1, others 0 → every bit flips each sweep; never stable. done after 8 sweeps, converged=0, sweep_count=8, neuros=INIT_PATTERN (even number of flips).
- Address trace for a single sweep → link_addr runs 0..624 exactly once, in order. rd_en is low for 2 cycles between neurons. Weight for neuron 1 comes from addresses 25..49.
- Hebbian weights for the D/C/J/M patterns; load D with 3 bits flipped, then start → neuros=D, converged=1.
- start pulsed at cycle 100 during busy → ignored. rst=0 at cycle 300 → next cycle neuros=INIT_PATTERN, busy=0, and no done pulse.

Source files
------------

// File: rtl/hopfield_pkg.sv
// Shared constants, FSM encoding and link-address helper for the Hopfield recall path.
package hopfield_pkg;
    localparam int N          = 25;
    localparam int WW         = 4;
    localparam int SUMW       = 8;
    localparam int AW         = 10;
    localparam int KW         = 5;
    localparam int MAX_SWEEPS = 8;
    localparam logic [N-1:0] INIT_PATTERN = 25'b0111010011100100001001110;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, COMMIT, SWEEP_END, FINISH} state_t;

    typedef struct packed {
        logic clr;
        logic en;
        logic sub;
    } mac_ctrl_t;

    function automatic logic [AW-1:0] link_index(input logic [KW-1:0] k, input logic [KW-1:0] m);
        return AW'(k) * AW'(N) + AW'(m);
    endfunction
endpackage

// File: rtl/hopfield_mac.sv
// Signed weight accumulator; the neuron bit picks +w or -w, pos flags a strictly positive sum.
module hopfield_mac
    import hopfield_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  mac_ctrl_t            ctrl,
    input  logic signed [WW-1:0] w,
    output logic                 pos
);
    logic signed [SUMW-1:0] sum;
    logic signed [SUMW-1:0] w_ext;

    assign w_ext = {{(SUMW-WW){w[WW-1]}}, w};
    assign pos   = !sum[SUMW-1] && (sum != '0);

    always_ff @(posedge clk) begin
        if (!rst)
            sum <= '0;
        else if (ctrl.clr)
            sum <= '0;
        else if (ctrl.en)
            sum <= ctrl.sub ? sum - w_ext : sum + w_ext;
    end
endmodule

// File: rtl/hopfield_recall_ctrl.sv
// Serial Hopfield recall: one link weight per cycle, one in-place neuron update per N+2 cycles.
module hopfield_recall_ctrl
    import hopfield_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          load,
    input  logic [N-1:0]  load_pattern,
    output logic          link_rd_en,
    output logic [AW-1:0] link_addr,
    input  logic [WW-1:0] link_data,
    output logic [N-1:0]  neuros,
    output logic          busy,
    output logic          done,
    output logic          converged,
    output logic [3:0]    sweep_count
);
    state_t        state;
    logic [KW-1:0] k, m, m_q;
    logic          rd_vld, changed, pos, chg_next, last_sweep, keep_going;
    mac_ctrl_t     mac_ctrl;

    assign chg_next   = changed | (pos != neuros[k]);
    assign last_sweep = (sweep_count == 4'(MAX_SWEEPS - 1));
    // Decided in the final COMMIT so the next sweep's first read overlaps SWEEP_END.
    assign keep_going = chg_next && !last_sweep;

    always_comb begin
        mac_ctrl.clr = (state == COMMIT) || (state == IDLE && start && !load);
        mac_ctrl.en  = rd_vld;
        mac_ctrl.sub = !neuros[m_q];
    end

    hopfield_mac u_mac (
        .clk  (clk),
        .rst  (rst),
        .ctrl (mac_ctrl),
        .w    (link_data),
        .pos  (pos)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            neuros      <= INIT_PATTERN;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            sweep_count <= '0;
            link_rd_en  <= 1'b0;
            link_addr   <= '0;
            k           <= '0;
            m           <= '0;
            m_q         <= '0;
            rd_vld      <= 1'b0;
            changed     <= 1'b0;
        end else begin
            // Synchronous RAM: data for the address issued now arrives next cycle.
            rd_vld <= link_rd_en;
            m_q    <= m;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        neuros <= load_pattern;
                    end else if (start) begin
                        k           <= '0;
                        m           <= '0;
                        changed     <= 1'b0;
                        sweep_count <= '0;
                        converged   <= 1'b0;
                        busy        <= 1'b1;
                        link_rd_en  <= 1'b1;
                        link_addr   <= link_index('0, '0);
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (m == KW'(N-1)) begin
                        link_rd_en <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        m         <= m + KW'(1);
                        link_addr <= link_addr + AW'(1);
                    end
                end
                DRAIN: state <= COMMIT;
                COMMIT: begin
                    neuros[k] <= pos;
                    changed   <= chg_next;
                    m         <= '0;
                    if (k != KW'(N-1)) begin
                        k          <= k + KW'(1);
                        link_rd_en <= 1'b1;
                        link_addr  <= link_index(k + KW'(1), '0);
                        state      <= FETCH;
                    end else begin
                        link_rd_en <= keep_going;
                        link_addr  <= '0;
                        state      <= SWEEP_END;
                    end
                end
                SWEEP_END: begin
                    sweep_count <= sweep_count + 4'd1;
                    if (!changed || last_sweep) begin
                        converged <= !changed;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        k         <= '0;
                        changed   <= 1'b0;
                        m         <= KW'(1);
                        link_addr <= AW'(1);
                        state     <= FETCH;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hopfield_recall_ctrl.sv
// Scoreboard bench: driver pushes model-predicted reads and results, a negedge monitor pops and compares.
module tb_hopfield_recall_ctrl;
    import hopfield_pkg::*;

    localparam int PER_NEURON = N + 2;
    localparam int PER_SWEEP  = N * PER_NEURON;

    typedef struct { int cyc; int addr; } addr_exp_t;
    typedef struct { int cyc; logic [N-1:0] x; bit conv; int sc; } done_exp_t;

    logic          clk = 1'b0;
    logic          rst, start, load;
    logic [N-1:0]  load_pattern;
    logic          link_rd_en;
    logic [AW-1:0] link_addr;
    logic [WW-1:0] link_data = '0;
    logic [N-1:0]  neuros;
    logic          busy, done, converged;
    logic [3:0]    sweep_count;

    int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
    int wts [N][N];
    logic [N-1:0] cur;
    logic [N-1:0] pats [4];
    addr_exp_t exp_addr [$];
    done_exp_t exp_done [$];
    addr_exp_t ea;
    done_exp_t ed;

    hopfield_recall_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .load(load), .load_pattern(load_pattern),
        .link_rd_en(link_rd_en), .link_addr(link_addr), .link_data(link_data),
        .neuros(neuros), .busy(busy), .done(done), .converged(converged),
        .sweep_count(sweep_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Link RAM model
    always @(posedge clk)
        if (link_rd_en && int'(link_addr) < N*N)
            link_data <= 4'(wts[int'(link_addr) / N][int'(link_addr) % N]);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (link_rd_en) begin
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected got addr=%0d cycle=%0d exp no read", link_addr, cyc);
                end else begin
                    ea = exp_addr.pop_front();
                    chk("rd_cycle", cyc, ea.cyc);
                    chk("rd_addr", 32'(link_addr), ea.addr);
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected got done=1 cycle=%0d exp no done", cyc);
                end else begin
                    ed = exp_done.pop_front();
                    chk("done_cycle", cyc, ed.cyc);
                    chk("done_neuros", 32'(neuros), 32'(ed.x));
                    chk("done_converged", 32'(converged), 32'(ed.conv));
                    chk("done_sweeps", 32'(sweep_count), ed.sc);
                    chk("busy_at_done", 32'(busy), 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous Hopfield recall straight from the update rule.
    task automatic model(input logic [N-1:0] x0, output logic [N-1:0] x, output int sweeps, output bit conv);
        bit ch, nb;
        int acc;
        x = x0; sweeps = 0; conv = 0;
        for (int s = 0; s < MAX_SWEEPS; s++) begin
            ch = 0;
            for (int kk = 0; kk < N; kk++) begin
                acc = 0;
                for (int mm = 0; mm < N; mm++) acc += x[mm] ? wts[kk][mm] : -wts[kk][mm];
                nb = (acc > 0);
                if (nb != x[kk]) ch = 1;
                x[kk] = nb;
            end
            sweeps++;
            if (!ch) begin conv = 1; break; end
        end
    endtask

    task automatic do_load(input logic [N-1:0] p);
        load_pattern = p; load = 1'b1;
        tick();
        load = 1'b0; cur = p;
    endtask

    task automatic do_start();
        logic [N-1:0] res;
        int s_cnt, c0;
        bit cv;
        model(cur, res, s_cnt, cv);
        c0 = cyc;
        for (int s = 0; s < s_cnt; s++)
            for (int a = 0; a < N*N; a++)
                exp_addr.push_back('{c0 + 1 + PER_SWEEP*s + PER_NEURON*(a/N) + a%N, a});
        exp_done.push_back('{c0 + 1 + s_cnt*PER_SWEEP + 1, res, cv, s_cnt});
        start = 1'b1;
        tick();
        start = 1'b0;
        cur = res;
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_done.size() != 0 && t < 6000) begin tick(); t++; end
        chk("done_seen", exp_done.size(), 0);
        tick(); tick();
        chk("addr_leftover", exp_addr.size(), 0);
        exp_done.delete(); exp_addr.delete();
    endtask

    task automatic set_diag(input int d);
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wts[i][j] = (i == j) ? d : 0;
    endtask

    initial begin
        int c0, dc;
        logic [N-1:0] p;
        rst = 1'b0; start = 1'b0; load = 1'b0; load_pattern = '0;
        cur = INIT_PATTERN;
        set_diag(0);
        pats[0] = 25'b11110_10001_10001_10001_11110;
        pats[1] = 25'b01111_10000_10000_10000_01111;
        pats[2] = 25'b00111_00010_00010_10010_01100;
        pats[3] = 25'b10001_11011_10101_10001_10001;
        tick(); tick(); tick();
        @(negedge clk);
        chk("rst_neuros", 32'(neuros), 32'(INIT_PATTERN));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_converged", 32'(converged), 0);
        chk("rst_sweeps", 32'(sweep_count), 0);
        chk("rst_rd_en", 32'(link_rd_en), 0);
        chk("rst_addr", 32'(link_addr), 0);
        tick();
        rst = 1'b1;
        tick();

        // all-zero weights: collapses to 0 then stabilises
        do_start(); wait_done();
        // +1 diagonal: INIT_PATTERN is already stable
        set_diag(1); do_load(INIT_PATTERN); do_start(); wait_done();
        // -1 diagonal: oscillates until the sweep limit
        set_diag(-1); do_start(); wait_done();

        // load beats start in the same cycle
        p = N'($urandom);
        load_pattern = p; load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0; cur = p;
        tick(); tick();
        @(negedge clk);
        chk("load_wins_busy", 32'(busy), 0);
        chk("load_wins_neuros", 32'(neuros), 32'(p));
        tick();

        // Hebbian store of four letters, probe with a noisy first letter
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                wts[i][j] = 0;
                if (i != j)
                    for (int q = 0; q < 4; q++)
                        wts[i][j] += (pats[q][i] ? 1 : -1) * (pats[q][j] ? 1 : -1);
            end
        do_load(pats[0] ^ 25'h0002081); do_start(); wait_done();

        // random symmetric weights in [-5,5] with random probes
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++)
                for (int j = i; j < N; j++) begin
                    wts[i][j] = int'($urandom_range(10)) - 5;
                    wts[j][i] = wts[i][j];
                end
            do_load(N'($urandom)); do_start(); wait_done();
        end

        // start while busy is ignored; reset mid-recall aborts without done
        do_load(N'($urandom));
        c0 = cyc;
        do_start();
        while (cyc < c0 + 100) tick();
        start = 1'b1; tick(); start = 1'b0;
        while (cyc < c0 + 300) tick();
        rst = 1'b0;
        tick();
        exp_addr.delete(); exp_done.delete();
        cur = INIT_PATTERN;
        dc = done_cnt;
        @(negedge clk);
        chk("abort_neuros", 32'(neuros), 32'(INIT_PATTERN));
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rd_en", 32'(link_rd_en), 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 800; i++) tick();
        chk("abort_no_done", done_cnt, dc);
        chk("abort_idle_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
